// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one main-memory port between the instruction and data caches.
// One transaction at a time: grant, capture, drive memory, register the line, pulse ready to the winner.
module mem_arbiter #(
    parameter int LINE_W  = 128,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_rdy,
    output logic [LINE_W-1:0] ic_rdata,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [LINE_W-1:0] dc_wdata,
    output logic              dc_rdy,
    output logic [LINE_W-1:0] dc_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_rdy,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic              timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IC = 2'd1,
        BUSY_DC = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_t            state_r;
    logic              prio_dc_r;
    logic [7:0]        timer_r;
    logic [LINE_W-1:0] resp_line_s;
    logic              timer_exp_s;

    // Line handed back to the winner: memory data on a read completion, zero for writes and aborts
    always_comb begin
        resp_line_s = {LINE_W{1'b0}};
        timer_exp_s = (timer_r == TIMER_LAST);
        if (mem_rdy && !mem_we) begin
            resp_line_s = mem_rdata;
        end else begin
            resp_line_s = {LINE_W{1'b0}};
        end
    end

    // Arbitration FSM with capture registers and registered requester/memory outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            prio_dc_r <= 1'b0;
            timer_r   <= 8'd0;
            ic_rdy    <= 1'b0;
            ic_rdata  <= {LINE_W{1'b0}};
            dc_rdy    <= 1'b0;
            dc_rdata  <= {LINE_W{1'b0}};
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= {ADDR_W{1'b0}};
            mem_wdata <= {LINE_W{1'b0}};
            timeout   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    // IC wins when alone or when it holds priority
                    if (ic_req && (!dc_req || !prio_dc_r)) begin
                        state_r   <= BUSY_IC;
                        prio_dc_r <= 1'b1;
                        timer_r   <= 8'd0;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= ic_addr;
                        mem_wdata <= {LINE_W{1'b0}};
                    end else if (dc_req) begin
                        state_r   <= BUSY_DC;
                        prio_dc_r <= 1'b0;
                        timer_r   <= 8'd0;
                        mem_req   <= 1'b1;
                        mem_we    <= dc_we;
                        mem_addr  <= dc_addr;
                        mem_wdata <= dc_wdata;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY_IC, BUSY_DC: begin
                    timer_r <= timer_r + 8'd1;
                    if (mem_rdy || timer_exp_s) begin
                        state_r  <= RESP;
                        mem_req  <= 1'b0;
                        ic_rdy   <= (state_r == BUSY_IC);
                        dc_rdy   <= (state_r == BUSY_DC);
                        ic_rdata <= (state_r == BUSY_IC) ? resp_line_s : {LINE_W{1'b0}};
                        dc_rdata <= (state_r == BUSY_DC) ? resp_line_s : {LINE_W{1'b0}};
                        timeout  <= !mem_rdy;
                    end else begin
                        state_r <= state_r;
                    end
                end
                RESP: begin
                    state_r  <= IDLE;
                    ic_rdy   <= 1'b0;
                    ic_rdata <= {LINE_W{1'b0}};
                    dc_rdy   <= 1'b0;
                    dc_rdata <= {LINE_W{1'b0}};
                    timeout  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: timestamp-based transaction model checked every cycle,
// plus hand-computed latency and data expectations per scenario.
module tb_mem_arbiter;

    localparam int TIMEOUT = 16;
    localparam logic [127:0] LINE_A = 128'h001080A3_003100B3_00108183_00108093;
    localparam logic [127:0] LINE_B = 128'h0BADF00D_12345678_9ABCDEF0_CAFEBABE;

    logic         clk;
    logic         rst;
    logic         ic_req;
    logic [31:0]  ic_addr;
    logic         ic_rdy;
    logic [127:0] ic_rdata;
    logic         dc_req;
    logic         dc_we;
    logic [31:0]  dc_addr;
    logic [127:0] dc_wdata;
    logic         dc_rdy;
    logic [127:0] dc_rdata;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic         mem_rdy;
    logic [127:0] mem_rdata;
    logic         timeout;

    mem_arbiter #(.LINE_W(128), .ADDR_W(32), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_rdy(ic_rdy), .ic_rdata(ic_rdata),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_rdy(dc_rdy), .dc_rdata(dc_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdy(mem_rdy), .mem_rdata(mem_rdata), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench memory: answers after mem_lat request cycles (0 = never), or a one-shot stray pulse
    int           mem_lat;
    logic [127:0] mem_line;
    int           stray_req;
    int           stray_done;
    int           mcnt;

    always @(negedge clk) begin
        if (rst) begin
            mem_rdy <= 1'b0;
            mcnt    <= 0;
        end else if (mem_rdy) begin
            mem_rdy <= 1'b0;
            mcnt    <= 0;
        end else if (stray_req != stray_done) begin
            stray_done <= stray_req;
            mem_rdy    <= 1'b1;
            mem_rdata  <= mem_line;
        end else if (mem_req) begin
            mcnt <= mcnt + 1;
            if (mem_lat > 0 && mcnt + 1 > mem_lat) begin
                mem_rdy   <= 1'b1;
                mem_rdata <= mem_line;
            end
        end else begin
            mcnt <= 0;
        end
    end

    // Transaction model: grant edge, response edge and captured request, all as timestamps
    int           n_run;
    int           n_fail;
    int           e;
    bit           m_active;
    bit           m_resp;
    bit           m_who;
    bit           m_prio;
    bit           m_abort;
    int           m_g;
    logic [127:0] m_line;
    logic [31:0]  m_addr;
    bit           m_we;
    logic [127:0] m_wdata;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, e);
        end
    endtask

    task automatic model_step();
        e++;
        if (rst) begin
            m_active = 1'b0; m_resp = 1'b0; m_prio = 1'b0; m_abort = 1'b0;
            m_line = '0; m_addr = '0; m_we = 1'b0; m_wdata = '0; m_who = 1'b0;
        end else if (m_resp) begin
            m_resp = 1'b0;
            m_active = 1'b0;
        end else if (m_active) begin
            if (mem_rdy) begin
                m_resp = 1'b1; m_abort = 1'b0;
                m_line = m_we ? 128'd0 : mem_rdata;
            end else if (e - m_g == TIMEOUT) begin
                m_resp = 1'b1; m_abort = 1'b1; m_line = 128'd0;
            end
        end else if (ic_req || dc_req) begin
            m_who    = !(ic_req && (!dc_req || !m_prio));
            m_prio   = !m_who;
            m_active = 1'b1;
            m_g      = e;
            m_addr   = m_who ? dc_addr : ic_addr;
            m_we     = m_who ? dc_we : 1'b0;
            m_wdata  = m_who ? dc_wdata : 128'd0;
        end
    endtask

    task automatic compare();
        bit ic_win;
        bit dc_win;
        ic_win = m_resp && !m_who;
        dc_win = m_resp && m_who;
        check("mem_req", 128'(mem_req), 128'(m_active && !m_resp));
        check("mem_we", 128'(mem_we), 128'(m_we));
        check("mem_addr", 128'(mem_addr), 128'(m_addr));
        check("mem_wdata", mem_wdata, m_wdata);
        check("ic_rdy", 128'(ic_rdy), 128'(ic_win));
        check("ic_rdata", ic_rdata, ic_win ? m_line : 128'd0);
        check("dc_rdy", 128'(dc_rdy), 128'(dc_win));
        check("dc_rdata", dc_rdata, dc_win ? m_line : 128'd0);
        check("timeout", 128'(timeout), 128'(m_resp && m_abort));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask

    // Hand-observed results of the last run
    logic [127:0] got_ic_data;
    logic [127:0] got_dc_data;
    logic         got_ic_to;
    logic         got_dc_to;
    logic [31:0]  last_addr;
    logic         last_we;
    logic [127:0] last_wdata;

    task automatic run(input int budget, input int chg_k, input logic [31:0] chg_addr,
                       output int k_ic, output int k_dc);
        k_ic = -1;
        k_dc = -1;
        for (int k = 1; k <= budget; k++) begin
            tick();
            if (k == chg_k) ic_addr = chg_addr;
            if (mem_req) begin
                last_addr = mem_addr; last_we = mem_we; last_wdata = mem_wdata;
            end
            if (ic_rdy && k_ic < 0) begin
                k_ic = k; got_ic_data = ic_rdata; got_ic_to = timeout; ic_req = 1'b0;
            end
            if (dc_rdy && k_dc < 0) begin
                k_dc = k; got_dc_data = dc_rdata; got_dc_to = timeout; dc_req = 1'b0;
            end
            if (!ic_req && !dc_req) break;
        end
        check("run_budget", 128'(ic_req || dc_req), 128'd0);
        ic_req = 1'b0;
        dc_req = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    int kic;
    int kdc;
    int pulses;

    initial begin
        n_run = 0; n_fail = 0; e = 0;
        rst = 1'b1; ic_req = 1'b0; ic_addr = 32'd0;
        dc_req = 1'b0; dc_we = 1'b0; dc_addr = 32'd0; dc_wdata = 128'd0;
        mem_lat = 1; mem_line = 128'd0; stray_req = 0; stray_done = 0; mcnt = 0;
        mem_rdy = 1'b0; mem_rdata = 128'd0;
        last_addr = 32'd0; last_we = 1'b0; last_wdata = 128'd0;
        m_active = 1'b0; m_resp = 1'b0; m_prio = 1'b0; m_g = 0;
        do_reset();
        tick();

        // IC alone, 1-cycle memory
        mem_line = LINE_A; ic_addr = 32'h100; ic_req = 1'b1;
        run(40, 0, 32'h0, kic, kdc);
        check("ic_alone_lat", 128'(kic), 128'(3));
        check("ic_alone_data", got_ic_data, LINE_A);
        check("ic_alone_no_dc", 128'(kdc), 128'(-1));

        // Both after an IC grant: DC holds priority
        mem_line = LINE_B; ic_addr = 32'h140; dc_addr = 32'h300; dc_we = 1'b0;
        ic_req = 1'b1; dc_req = 1'b1;
        run(40, 0, 32'h0, kic, kdc);
        check("rr_dc_first", 128'(kdc), 128'(3));
        check("rr_ic_second", 128'(kic), 128'(7));
        check("rr_dc_data", got_dc_data, LINE_B);

        // Both right after reset: IC first
        do_reset();
        ic_req = 1'b1; dc_req = 1'b1;
        run(40, 0, 32'h0, kic, kdc);
        check("rst_ic_first", 128'(kic), 128'(3));
        check("rst_dc_second", 128'(kdc), 128'(7));

        // DC write with 2-cycle memory
        mem_lat = 2; mem_line = LINE_A;
        dc_we = 1'b1; dc_addr = 32'h200; dc_wdata = 128'hDEADBEEF; dc_req = 1'b1;
        run(40, 0, 32'h0, kic, kdc);
        check("wr_lat", 128'(kdc), 128'(4));
        check("wr_rdata", got_dc_data, 128'd0);
        check("wr_mem_we", 128'(last_we), 128'd1);
        check("wr_mem_addr", 128'(last_addr), 128'h200);
        check("wr_mem_wdata", last_wdata, 128'hDEADBEEF);
        dc_we = 1'b0;

        // Memory never answers: abort after TIMEOUT busy cycles
        mem_lat = 0; ic_addr = 32'h180; ic_req = 1'b1;
        run(60, 0, 32'h0, kic, kdc);
        check("to_lat", 128'(kic), 128'(TIMEOUT + 1));
        check("to_flag", 128'(got_ic_to), 128'd1);
        check("to_rdata", got_ic_data, 128'd0);
        mem_lat = 1; mem_line = LINE_B; dc_addr = 32'h240; dc_req = 1'b1;
        run(40, 0, 32'h0, kic, kdc);
        check("after_to_lat", 128'(kdc), 128'(3));
        check("after_to_flag", 128'(got_dc_to), 128'd0);
        check("after_to_data", got_dc_data, LINE_B);

        // Address change after grant must not reach memory
        mem_lat = 3; ic_addr = 32'h100; ic_req = 1'b1;
        run(40, 1, 32'h140, kic, kdc);
        check("chg_lat", 128'(kic), 128'(5));
        check("chg_mem_addr", 128'(last_addr), 128'h100);

        // Reset during BUSY_DC, then a stray memory reply
        mem_lat = 0; dc_addr = 32'h280; dc_req = 1'b1;
        tick(); tick(); tick();
        rst = 1'b1; dc_req = 1'b0;
        tick(); tick();
        rst = 1'b0;
        stray_req = 1;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (ic_rdy || dc_rdy || mem_req) pulses++;
        end
        check("stray_quiet", 128'(pulses), 128'd0);
        mem_lat = 1; mem_line = LINE_A; ic_addr = 32'h1C0; ic_req = 1'b1;
        run(40, 0, 32'h0, kic, kdc);
        check("post_rst_lat", 128'(kic), 128'(3));
        check("post_rst_data", got_ic_data, LINE_A);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
